rf_wport_arbiter: RTL
=====================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stream (WB stage)
//  and one long-latency unit (LU: divider/CSR results returning out of band).
//  Holds the LU result in a 1-entry buffer and grants the port to WB by default.
//  An anti-starvation wait counter forces an LU grant by stalling WB.
//  Also drives the dest/value forwarding pair toward ID for the write performed this cycle.
// PARAMETERS
//  MAX_WAIT  4   cycles a buffered LU result may lose arbitration before it is forced (>=1)
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  wb_valid   in   1       WB stage presents a retiring instruction
//  wb_bus     in   38      {we[37], waddr[36:32], wdata[31:0]} from WB
//  wb_ready   out  1       WB may retire this cycle (feeds WB ready_go)
//  lu_valid   in   1       LU offers a result
//  lu_bus     in   38      {we, waddr, wdata}, same packing as wb_bus
//  lu_ready   out  1       1-entry LU buffer is free
//  rf_we      out  1       register-file write enable
//  rf_waddr   out  5       register-file write address
//  rf_wdata   out  32      register-file write data
//  fwd_dest   out  5       dest written this cycle, 0 if none (to ID bypass)
//  fwd_value  out  32      value written this cycle, 0 if none
// BEHAVIOUR
//  - Reset: buf_valid=0, wait_cnt=0, state=S_EMPTY; outputs: lu_ready=1, rf_we=0, fwd_dest=0,
//    fwd_value=0, wb_ready=1.
//  - A request "needs the port" iff valid && we && waddr!=0. A write to r0 is discarded:
//    the entry retires without a port grant.
//  - LU buffer: captured on lu_valid && lu_ready; lu_ready = !buf_valid (no same-cycle refill).
//    Earliest rf write is the cycle after capture.
//  - WB path is combinational: a granted WB write reaches rf_* in the same cycle.
//  - FSM:
//      S_EMPTY: buffer empty. WB always granted. Capture -> S_WAIT.
//      S_WAIT: buffer full.
//        - LU granted if WB does not need the port -> S_EMPTY. If WB is valid without a write,
//          wb_ready=1 in the same cycle.
//        - Otherwise WB granted and wait_cnt++. When wait_cnt reaches MAX_WAIT-1 with a WB
//          grant -> S_FORCE.
//      S_FORCE: LU granted unconditionally, wb_ready = !(WB needs port) -> S_EMPTY.
//  - wait_cnt clears whenever the buffer drains. Width is $clog2(MAX_WAIT+1); it saturates
//    and never wraps.
//  - fwd_dest/fwd_value equal rf_waddr/rf_wdata when rf_we, else 0.
//  - Write ordering: issue logic guarantees no WAW between the buffered LU entry and
//    in-flight WB writes. The arbiter does not compare addresses.
//  - Reset mid-operation: a buffered result is dropped and no rf write occurs after reset
//    asserts.
// CONFIGURATION
//  RF_ARB_STAT_EN defined: adds outputs stat_lu_grants[31:0] and stat_wb_stalls[31:0].
//    - stat_lu_grants counts cycles with an LU grant; stat_wb_stalls counts cycles with
//      wb_valid && !wb_ready.
//    - Both are cleared by reset and wrap modulo 2^32.
//  Undefined: no counters and no such ports; all other behaviour is identical.
// STRUCTURE
//  Shared package/header:
//    - RF_BUS_W=38 plus field offsets for we/waddr/wdata.
//    - FSM state encodings S_EMPTY/S_WAIT/S_FORCE (2-bit).
//    - MAX_WAIT default.
//  One sub-module, rf_wport_buf: the 1-entry LU holding register with valid/ready.
//  The FSM, counter and output mux live in the top module.
// TESTING
//  1. Reset with traffic present -> rf_we=0, lu_ready=1, wb_ready=1, fwd_dest=0 while reset
//     is high.
//  2. wb_bus={1,5'd3,32'h1234}, no LU -> same cycle rf_we=1, waddr=3, wdata=0x1234,
//     fwd_dest=3.
//  3. LU {1,5'd7,32'hAA} at cycle N with WB idle -> rf write r7=0xAA at N+1, lu_ready=0 at N+1,
//     back to 1 at N+2.
//  4. LU buffered, WB writes every cycle, MAX_WAIT=4 -> WB wins 4 cycles. Cycle 5: LU written,
//     wb_ready=0. Cycle 6: WB resumes.
//  5. Buffered LU with WB {we=0} -> LU written and wb_ready=1 in the same cycle. WB/LU writes
//     to r0 -> rf_we=0 and both retire.
//  6. Async reset asserted mid-S_WAIT -> buffer cleared with no rf write. With RF_ARB_STAT_EN,
//     counters read 0 after reset and match the grant/stall counts of scenario 4 (1 and 1).

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants, bus layout and FSM encodings for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

   localparam int unsigned RF_ADDR_W       = 5;
   localparam int unsigned RF_DATA_W       = 32;
   localparam int unsigned RF_BUS_W        = 1 + RF_ADDR_W + RF_DATA_W;
   localparam int unsigned RF_WE_BIT       = RF_ADDR_W + RF_DATA_W;
   localparam int unsigned RF_WADDR_LSB    = RF_DATA_W;
   localparam int unsigned RF_WDATA_LSB    = 0;
   localparam int unsigned RF_MAX_WAIT_DEF = 4;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WAIT  = 2'd1,
      S_FORCE = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                 we;
      logic [RF_ADDR_W-1:0] waddr;
      logic [RF_DATA_W-1:0] wdata;
   } rf_wr_t;

endpackage

// File: rtl/rf_wport_buf.sv
// One-entry holding register for the long-latency unit result; no same-cycle refill.
module rf_wport_buf
   import rf_wport_arbiter_pkg::*;
#(
   parameter int unsigned BUS_W = RF_BUS_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [BUS_W-1:0] in_bus,
   output logic             in_ready,
   input  logic             drain,
   output logic             out_valid,
   output logic [BUS_W-1:0] out_bus
);

   logic             valid_q, valid_d;
   logic [BUS_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (!valid_q && in_valid) begin
         valid_d = 1'b1;
         data_d  = in_bus;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = !valid_q;
   assign out_valid = valid_q;
   assign out_bus   = data_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (default winner) and a buffered long-latency result.
// Define RF_ARB_STAT_EN to add the LU-grant and WB-stall statistics counters.
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = RF_MAX_WAIT_DEF,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned DATA_W   = RF_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   input  logic [ADDR_W+DATA_W:0]   wb_bus,
   output logic                     wb_ready,
   input  logic                     lu_valid,
   input  logic [ADDR_W+DATA_W:0]   lu_bus,
   output logic                     lu_ready,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic [ADDR_W-1:0]        fwd_dest,
   output logic [DATA_W-1:0]        fwd_value
`ifdef RF_ARB_STAT_EN
   ,
   output logic [31:0]              stat_lu_grants,
   output logic [31:0]              stat_wb_stalls
`endif
);

   localparam int unsigned BUS_W = 1 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic             buf_valid, buf_drain;
   logic [BUS_W-1:0] buf_bus;
   logic             lu_grant, wb_grant;

   rf_wport_buf #(.BUS_W(BUS_W)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (lu_valid),
      .in_bus    (lu_bus),
      .in_ready  (lu_ready),
      .drain     (buf_drain),
      .out_valid (buf_valid),
      .out_bus   (buf_bus)
   );

   logic              wb_we, buf_we;
   logic [ADDR_W-1:0] wb_waddr, buf_waddr;
   logic [DATA_W-1:0] wb_wdata, buf_wdata;
   logic              wb_needs, buf_needs;

   assign wb_we     = wb_bus[BUS_W-1];
   assign wb_waddr  = wb_bus[DATA_W +: ADDR_W];
   assign wb_wdata  = wb_bus[DATA_W-1:0];
   assign buf_we    = buf_bus[BUS_W-1];
   assign buf_waddr = buf_bus[DATA_W +: ADDR_W];
   assign buf_wdata = buf_bus[DATA_W-1:0];

   // Writes to r0 never occupy the port.
   assign wb_needs  = wb_valid && wb_we && (wb_waddr != '0);
   assign buf_needs = buf_valid && buf_we && (buf_waddr != '0);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      lu_grant   = 1'b0;
      buf_drain  = 1'b0;
      wb_ready   = 1'b1;
      unique case (state_q)
         S_EMPTY: begin
            if (lu_valid && lu_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!buf_needs || !wb_needs) begin
               lu_grant   = buf_needs;
               buf_drain  = 1'b1;
               wait_cnt_d = '0;
               state_d    = S_EMPTY;
            end else begin
               if (wait_cnt_q != CNT_W'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
               if (wait_cnt_q >= CNT_W'(MAX_WAIT - 1)) state_d = S_FORCE;
            end
         end
         S_FORCE: begin
            lu_grant   = buf_needs;
            buf_drain  = 1'b1;
            wb_ready   = !wb_needs;
            wait_cnt_d = '0;
            state_d    = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
      // Nothing reaches the register file while reset is held.
      if (reset) begin
         lu_grant  = 1'b0;
         buf_drain = 1'b0;
         wb_ready  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign wb_grant = wb_needs && wb_ready && !reset;

   always_comb begin
      rf_we    = lu_grant || wb_grant;
      rf_waddr = '0;
      rf_wdata = '0;
      if (lu_grant) begin
         rf_waddr = buf_waddr;
         rf_wdata = buf_wdata;
      end else if (wb_grant) begin
         rf_waddr = wb_waddr;
         rf_wdata = wb_wdata;
      end
      fwd_dest  = rf_we ? rf_waddr : '0;
      fwd_value = rf_we ? rf_wdata : '0;
   end

`ifdef RF_ARB_STAT_EN
   logic [31:0] lu_grants_q, lu_grants_d;
   logic [31:0] wb_stalls_q, wb_stalls_d;

   always_comb begin
      lu_grants_d = lu_grants_q + 32'(lu_grant);
      wb_stalls_d = wb_stalls_q + 32'(wb_valid && !wb_ready);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lu_grants_q <= '0;
         wb_stalls_q <= '0;
      end else begin
         lu_grants_q <= lu_grants_d;
         wb_stalls_q <= wb_stalls_d;
      end
   end

   assign stat_lu_grants = lu_grants_q;
   assign stat_wb_stalls = wb_stalls_q;
`endif

endmodule
